// File: rtl/full_adder_core_pkg.sv
// Shared constants for the full_adder_core slice: legal operand width range.
package full_adder_core_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;

    function automatic bit width_legal(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full-adder cell; the leaf of the ripple chain.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule

// File: rtl/full_adder_core.sv
// Ripple-carry adder of WIDTH full_adder_bit cells with registered sum and carry out.
module full_adder_core
    import full_adder_core_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic [WIDTH-1:0] S,
    output logic             C_out
);

    localparam logic [WIDTH-1:0] SUM_RST = '0;

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("full_adder_core: WIDTH must be within 1..64");
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = C_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_bit (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    logic [WIDTH-1:0] s_d, s_q;
    logic             c_out_d, c_out_q;

    always_comb begin
        s_d     = s;
        c_out_d = c[WIDTH];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_q     <= SUM_RST;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_out_q <= c_out_d;
        end
    end

    assign S     = s_q;
    assign C_out = c_out_q;

endmodule

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core at WIDTH=1 and WIDTH=8 against an arithmetic model.
module tb_full_adder_core;

    logic       clock = 1'b0;
    logic       reset;
    logic       a1, b1, cin1, s1, cout1;
    logic [7:0] a8, b8, s8;
    logic       cin8, cout8;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    full_adder_core #(.WIDTH(1)) dut_w1 (
        .clock (clock),
        .reset (reset),
        .A     (a1),
        .B     (b1),
        .C_in  (cin1),
        .S     (s1),
        .C_out (cout1)
    );

    full_adder_core #(.WIDTH(8)) dut_w8 (
        .clock (clock),
        .reset (reset),
        .A     (a8),
        .B     (b8),
        .C_in  (cin8),
        .S     (s8),
        .C_out (cout8)
    );

    // Reference: plain integer addition, 9-bit result {carry, sum}.
    function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int unsigned total;
        total = int'(a) + int'(b) + (ci ? 1 : 0);
        return total[8:0];
    endfunction

    task automatic test_reset();
        logic [8:0] e8;
        reset = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if ({cout1, s1} !== 2'b00) begin
                errors++;
                $display("FAIL reset_w1 cycle %0d: got C_out=%b S=%b, want C_out=0 S=0", i, cout1, s1);
            end
            checks++;
            if ({cout8, s8} !== 9'h000) begin
                errors++;
                $display("FAIL reset_w8 cycle %0d: got C_out=%b S=%h, want C_out=0 S=00", i, cout8, s8);
            end
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({cout1, s1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_w1: got C_out=%b S=%b, want C_out=1 S=1", cout1, s1);
        end
        e8 = ref_add8(8'h01, 8'h01, 1'b1);
        checks++;
        if ({cout8, s8} !== e8) begin
            errors++;
            $display("FAIL reset_release_w8: got %b_%h, want %b_%h", cout8, s8, e8[8], e8[7:0]);
        end
    endtask

    task automatic test_exhaustive_w1();
        int unsigned total;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; cin1 = i[0];
            total = (i[2] ? 1 : 0) + (i[1] ? 1 : 0) + (i[0] ? 1 : 0);
            @(negedge clock);
            checks++;
            if ({cout1, s1} !== total[1:0]) begin
                errors++;
                $display("FAIL exhaustive_w1 a=%b b=%b cin=%b: got C_out=%b S=%b, want C_out=%b S=%b",
                         i[2], i[1], i[0], cout1, s1, total[1], total[0]);
            end
        end
    endtask

    task automatic test_latency();
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clock);
        a1 = 1'b0;
        checks++;
        if (s1 !== 1'b1) begin
            errors++;
            $display("FAIL latency_first: got S=%b, want 1", s1);
        end
        @(negedge clock);
        checks++;
        if (s1 !== 1'b0) begin
            errors++;
            $display("FAIL latency_second: got S=%b, want 0", s1);
        end
    endtask

    task automatic test_carry_chain_w8();
        logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'hFF, 8'h00};
        logic [7:0] vb [4] = '{8'h00, 8'h01, 8'hFF, 8'h00};
        logic       vc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0] want [4] = '{9'h100, 9'h080, 9'h1FF, 9'h000};
        for (int i = 0; i < 4; i++) begin
            a8 = va[i]; b8 = vb[i]; cin8 = vc[i];
            @(negedge clock);
            checks++;
            if ({cout8, s8} !== want[i]) begin
                errors++;
                $display("FAIL carry_chain_w8 #%0d: got C_out=%b S=%h, want C_out=%b S=%h",
                         i, cout8, s8, want[i][8], want[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back_w8();
        logic [8:0] pending [$];
        logic [8:0] e;
        for (int i = 0; i < 1001; i++) begin
            if (i < 1000) begin
                if (i == 500) begin
                    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
                end else begin
                    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                end
                pending.push_back(ref_add8(a8, b8, cin8));
            end
            @(negedge clock);
            if (pending.size() > 0 && i < 1000) begin
                e = pending.pop_front();
                checks++;
                if ({cout8, s8} !== e) begin
                    errors++;
                    $display("FAIL back_to_back_w8 #%0d: got C_out=%b S=%h, want C_out=%b S=%h",
                             i, cout8, s8, e[8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] e;
        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            reset = (i == 10);
            e = reset ? 9'h000 : ref_add8(a8, b8, cin8);
            @(negedge clock);
            checks++;
            if ({cout8, s8} !== e) begin
                errors++;
                $display("FAIL mid_reset_w8 #%0d (reset=%b): got C_out=%b S=%h, want C_out=%b S=%h",
                         i, reset, cout8, s8, e[8], e[7:0]);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_exhaustive_w1();
        test_latency();
        test_carry_chain_w8();
        test_back_to_back_w8();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
